// File: rtl/osd_mam_arb_pkg.sv
// Shared helpers for the MAM arbiter slice.
// Index arithmetic only; channel types stay local to each block.
package osd_mam_arb_pkg;

    localparam int MAX_MASTERS = 8;

    function automatic int rr_idx(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/osd_mam_arb_rr.sv
// Round-robin pick: first requester after the last owner, wrapping.
// Pure combinational; the owner register lives in the caller.
module osd_mam_arb_rr
    import osd_mam_arb_pkg::*;
#(
    parameter  int N  = 2,
    localparam int GW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [GW-1:0] last_i,
    output logic [GW-1:0] win_o,
    output logic          any_o
);

    int idx;

    // Walk offsets from far to near so the nearest requester wins.
    always_comb begin
        win_o = '0;
        any_o = 1'b0;
        idx   = 0;
        for (int i = N; i >= 1; i--) begin
            idx = rr_idx(int'(last_i), i, N);
            if (req_i[idx]) begin
                win_o = GW'(idx);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/osd_mam_arb.sv
// Multi-master MAM arbiter: one owner at a time holds the
// memory-side request, write and read channels until its burst ends.
module osd_mam_arb
    import osd_mam_arb_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int ADDR_WIDTH = 32,
    parameter  int MASTERS    = 2,
    localparam int GW         = $clog2(MASTERS),
    localparam int BW         = 14,
    localparam int SW         = DATA_WIDTH / 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [MASTERS-1:0]                    m_req_valid,
    output logic [MASTERS-1:0]                    m_req_ready,
    input  logic [MASTERS-1:0]                    m_req_rw,
    input  logic [MASTERS-1:0]                    m_req_burst,
    input  logic [MASTERS-1:0][ADDR_WIDTH-1:0]    m_req_addr,
    input  logic [MASTERS-1:0][BW-1:0]            m_req_beats,
    input  logic [MASTERS-1:0]                    m_write_valid,
    input  logic [MASTERS-1:0][DATA_WIDTH-1:0]    m_write_data,
    input  logic [MASTERS-1:0][SW-1:0]            m_write_strb,
    output logic [MASTERS-1:0]                    m_write_ready,
    output logic [MASTERS-1:0]                    m_read_valid,
    output logic [MASTERS-1:0][DATA_WIDTH-1:0]    m_read_data,
    input  logic [MASTERS-1:0]                    m_read_ready,
    output logic                                  s_req_valid,
    input  logic                                  s_req_ready,
    output logic                                  s_req_rw,
    output logic                                  s_req_burst,
    output logic [ADDR_WIDTH-1:0]                 s_req_addr,
    output logic [BW-1:0]                         s_req_beats,
    output logic                                  s_write_valid,
    output logic [DATA_WIDTH-1:0]                 s_write_data,
    output logic [SW-1:0]                         s_write_strb,
    input  logic                                  s_write_ready,
    input  logic                                  s_read_valid,
    input  logic [DATA_WIDTH-1:0]                 s_read_data,
    output logic                                  s_read_ready,
    output logic [GW-1:0]                         grant,
    output logic                                  grant_valid
);

    typedef enum logic [1:0] {IDLE, REQ, WRITE, READ} state_e;

    state_e        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_q, last_d;
    logic [BW-1:0] rem_q, rem_d;
    logic [GW-1:0] rr_win;
    logic          rr_any;
    logic          beat;

    osd_mam_arb_rr #(.N(MASTERS)) u_rr (
        .req_i  (m_req_valid),
        .last_i (last_q),
        .win_o  (rr_win),
        .any_o  (rr_any)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= GW'(MASTERS - 1);
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_d        = last_q;
        rem_d         = rem_q;
        beat          = 1'b0;
        m_req_ready   = '0;
        m_write_ready = '0;
        m_read_valid  = '0;
        m_read_data   = '0;
        s_req_valid   = 1'b0;
        s_req_rw      = m_req_rw[grant_q];
        s_req_burst   = m_req_burst[grant_q];
        s_req_addr    = m_req_addr[grant_q];
        s_req_beats   = m_req_beats[grant_q];
        s_write_valid = 1'b0;
        s_write_data  = m_write_data[grant_q];
        s_write_strb  = m_write_strb[grant_q];
        s_read_ready  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rr_any) begin
                    grant_d = rr_win;
                    state_d = REQ;
                end
            end
            REQ: begin
                s_req_valid          = m_req_valid[grant_q];
                m_req_ready[grant_q] = s_req_ready;
                if (s_req_valid && s_req_ready) begin
                    // Zero-length bursts collapse to one beat.
                    if (s_req_burst && s_req_beats != '0)
                        rem_d = s_req_beats;
                    else
                        rem_d = BW'(1);
                    state_d = s_req_rw ? WRITE : READ;
                end
            end
            WRITE: begin
                s_write_valid          = m_write_valid[grant_q];
                m_write_ready[grant_q] = s_write_ready;
                beat = s_write_valid && s_write_ready;
            end
            READ: begin
                m_read_valid[grant_q] = s_read_valid;
                if (s_read_valid)
                    m_read_data[grant_q] = s_read_data;
                s_read_ready = m_read_ready[grant_q];
                beat = s_read_valid && s_read_ready;
            end
            default: state_d = IDLE;
        endcase

        if (beat) begin
            if (rem_q <= BW'(1)) begin
                rem_d   = '0;
                last_d  = grant_q;
                state_d = IDLE;
            end else begin
                rem_d = rem_q - BW'(1);
            end
        end
    end

    assign grant       = grant_q;
    assign grant_valid = (state_q != IDLE);

endmodule
